muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the decode stage.
- Consumes the two register operands (Rdata1 = rs, Rdata2 = rt) and executes MIPS MULT/MULTU/DIV/DIVU over multiple cycles.
- Results go into architectural HI/LO registers, which MFHI/MFLO read back on the write-back path.
- Exposes Busy so the control path can stall further mul/div issue and HI/LO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  issue request; sampled only in IDLE.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; other codes are no-op.
- Rdata1  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- Rdata2  input  WIDTH  rt operand (multiplier / divisor).
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when HI/LO take a mul/div result.
- HI  output  WIDTH  HI register (product high / remainder).
- LO  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0. Reset mid-operation aborts it; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Op in 000..011:
  - Latch operands and op; go to CALC with counter=0.
  - Signed ops (MULT, DIV) latch absolute values and record result sign(s).
- IDLE, Start=1, Op in 100/101: handled by the optional feature; otherwise ignored, state stays IDLE.
- CALC: one iteration per cycle, for exactly WIDTH cycles, then go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle; the remainder is WIDTH+1 bits internally.
- FIX, one cycle:
  - Apply two's-complement sign correction.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative if the signs differ; remainder takes the dividend's sign.
  - Write HI/LO, return to IDLE, assert Done for the following cycle.
- Latency: Start sampled at edge 0 gives HI/LO updated at edge WIDTH+1 (33). Busy=1 from edge 0 until edge 33. Done=1 for the single cycle after edge 33.
- Start while Busy=1 is ignored; operands are not re-latched.
- Start in the same cycle that Done=1 is accepted, because the state is already IDLE.
- HI/LO hold their old values throughout CALC; they change only in FIX.
- Divide by zero (DIV or DIVU, Rdata2=0): HI=dividend as supplied, LO=all ones. Same latency, Done still pulses.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy and Done are registered outputs.

Optional Feature:
- Macro: MULDIV_MTHI_MTLO_EN.
- Defined:
  - In IDLE, Start=1 with Op=100 writes HI<=Rdata1.
  - In IDLE, Start=1 with Op=101 writes LO<=Rdata1.
  - Single cycle, no Busy, no Done.
- Undefined: Op 100/101 is a no-op, and HI/LO are writable only by mul/div results.

Test Plan:
- MULT Rdata1=0xFFFFFFFD (-3), Rdata2=7 -> Busy high for 33 cycles, then Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Second Start issued while Busy is ignored, and the result is unchanged.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 100/0 -> HI=100, LO=0xFFFFFFFF, Done pulses at cycle 34. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Reset pulsed low at cycle 10 of a MULT -> HI=LO=0, Busy=0 immediately (asynchronous). A new DIVU started after reset completes correctly. Also check a Start issued in the Done cycle is accepted.
- With MULDIV_MTHI_MTLO_EN: MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> HI/LO updated next edge, Busy stays 0. Without the macro, the same stimulus leaves HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module : muldiv_unit_if
// Brief  : Issue/result bundle between the execute stage and muldiv_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Rdata1;
  logic [WIDTH-1:0] Rdata2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, Rdata1, Rdata2, input Busy, Done, HI, LO);
  modport slave  (input Start, Op, Rdata1, Rdata2, output Busy, Done, HI, LO);
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
//          Optional MTHI/MTLO writes enabled by macro MULDIV_MTHI_MTLO_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  muldiv_unit_if.slave    bus
);

  localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operation context captured at issue
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;

  logic               w_accept;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remf;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          if (!bus.Op[2]) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CALC;
          end else begin
`ifdef MULDIV_MTHI_MTLO_EN
            w_mthi = (bus.Op[1:0] == 2'b00);
            w_mtlo = (bus.Op[1:0] == 2'b01);
`endif
          end
        end
      end
      S_CALC: begin
        if (r_cnt == c_last) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    w_signed = ~bus.Op[0];
    w_abs_a  = (w_signed && bus.Rdata1[WIDTH-1]) ? (~bus.Rdata1 + 1'b1) : bus.Rdata1;
    w_abs_b  = (w_signed && bus.Rdata2[WIDTH-1]) ? (~bus.Rdata2 + 1'b1) : bus.Rdata2;

    // Shift-add: multiplier sits in the low half and is consumed LSB first
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: quotient shifts in where the dividend shifts out
    w_div_shift = {r_rem, r_acc[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};

    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_divzero ? '1 : (r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
    w_remf = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divzero <= 1'b0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_is_div  <= bus.Op[1];
      r_neg_q   <= w_signed & (bus.Rdata1[WIDTH-1] ^ bus.Rdata2[WIDTH-1]);
      r_neg_r   <= w_signed & bus.Rdata1[WIDTH-1];
      r_divzero <= bus.Op[1] & (bus.Rdata2 == '0);
      r_opb     <= bus.Op[1] ? w_abs_b : w_abs_a;
      r_acc     <= {{WIDTH{1'b0}}, (bus.Op[1] ? w_abs_a : w_abs_b)};
      r_rem     <= '0;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div) begin
        if (!w_div_diff[WIDTH]) begin
          r_rem <= w_div_diff[WIDTH-1:0];
        end else begin
          r_rem <= w_div_shift[WIDTH-1:0];
        end
        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_div_diff[WIDTH]};
      end else begin
        r_acc <= w_mul_nxt;
      end
    end
  end

  // ---------------------------------------------------------------- HI/LO
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      if (r_is_div) begin
        r_hi <= w_remf;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else begin
      if (w_mthi) begin
        r_hi <= bus.Rdata1;
      end
      if (w_mtlo) begin
        r_lo <= bus.Rdata1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Randomised and directed bench for muldiv_unit against an
//          arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_err;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {HI, LO} from plain MIPS arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    model = 64'd0;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); model = sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b};     model = up; end
      3'd2: begin
        if (b == 32'd0)                                 model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else                                             model = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else            model = {a % b, a / b};
      end
      default: model = 64'd0;
    endcase
  endfunction

  // Issue one mul/div and follow it to Done; optionally poke Start while busy
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int          n;
    bit          held;
    exp = model(op, a, b);
    @(negedge CLK);
    hi0        = bus.HI;
    lo0        = bus.LO;
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.Rdata1 = a;
    bus.Rdata2 = b;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    check({tag, "_busy_up"}, 64'(bus.Busy), 64'd1);
    n    = 0;
    held = 1'b1;
    while (bus.Busy && n < 40) begin
      if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
      if (poke && n == 5) begin
        bus.Start  = 1'b1;
        bus.Op     = 3'd3;
        bus.Rdata1 = ~a;
        bus.Rdata2 = 32'd3;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge CLK);
      #1;
      n++;
    end
    bus.Start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_held"},    64'(held), 64'd1);
    check({tag, "_done"},    64'(bus.Done), 64'd1);
    check({tag, "_hilo"},    {bus.HI, bus.LO}, exp);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] hi_s, lo_s;
    n_checks   = 0;
    n_err      = 0;
    RST        = 1'b0;
    bus.Start  = 1'b0;
    bus.Op     = 3'd0;
    bus.Rdata1 = '0;
    bus.Rdata2 = '0;
    repeat (2) @(negedge CLK);
    check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    RST = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_const", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(posedge CLK);
    #1;
    check("done_one_cycle", 64'(bus.Done), 64'd0);

    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max_const", {bus.HI, bus.LO}, {32'hFFFF_FFFE, 32'h0000_0001});

    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_const", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Back-to-back: issued while Done is still high
    check("done_before_b2b", 64'(bus.Done), 64'd1);
    do_op("divu_b2b", 3'd3, 32'd100, 32'd7, 1'b0);
    check("divu_const", {bus.HI, bus.LO}, {32'd2, 32'd14});

    do_op("divu_zero", 3'd3, 32'd100, 32'd0, 1'b0);
    check("divu_zero_const", {bus.HI, bus.LO}, {32'd100, 32'hFFFF_FFFF});
    do_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_const", {bus.HI, bus.LO}, {32'd0, 32'h8000_0000});
    do_op("divu_seed", 3'd3, 32'd100, 32'd7, 1'b0);

    // Asynchronous reset in the middle of a MULT
    @(negedge CLK);
    bus.Start  = 1'b1;
    bus.Op     = 3'd0;
    bus.Rdata1 = 32'h1234_5678;
    bus.Rdata2 = 32'h0000_1000;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("arst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("arst_busy", 64'(bus.Busy), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    do_op("divu_after_rst", 3'd3, 32'd1000, 32'd33, 1'b0);

    // MTHI/MTLO
    hi_s = bus.HI;
    lo_s = bus.LO;
    @(negedge CLK);
    bus.Start  = 1'b1;
    bus.Op     = 3'b100;
    bus.Rdata1 = 32'h1234_5678;
    @(negedge CLK);
    bus.Op     = 3'b101;
    bus.Rdata1 = 32'h9ABC_DEF0;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    check("mt_busy", 64'(bus.Busy), 64'd0);
`ifdef MULDIV_MTHI_MTLO_EN
    check("mt_hilo", {bus.HI, bus.LO}, {32'h1234_5678, 32'h9ABC_DEF0});
`else
    check("mt_hilo", {bus.HI, bus.LO}, {hi_s, lo_s});
`endif
    check("mt_done", 64'(bus.Done), 64'd0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 255));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op("rand", rop, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
